instr_prefetch_queue: RTL and testbench

Instruction prefetch queue between instruction memory and the IF stage. Issues sequential word fetches over a valid/ready request channel with variable-latency in-order responses. Buffers up to DEPTH {pc, instr} entries and presents them to IF with stall backpressure. On a redirect (misprediction, jump or flush) it empties itself, restarts at the redirect PC and drops stale in-flight responses.

---
 rtl/instr_prefetch_queue.sv | 145 ++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential imem fetch with credit-based issue, in-order
// response buffering, and redirect flush with stale-beat discard. Optional perf counters: PFQ_PERF_EN.
package pfq_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pfq_entry_t;
endpackage

module instr_prefetch_queue
  import pfq_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcnext
`ifdef PFQ_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt,
  output logic [31:0] perf_empty_stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  pfq_entry_t    r_mem [DEPTH];
  logic [31:0]   r_fetch_pc, r_rsp_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [OW-1:0] r_outst, r_discard;

  logic [31:0]   w_fetch_pc_n, w_rsp_pc_n, w_redirect_pc;
  logic [CW-1:0] w_count_n;
  logic [PW-1:0] w_rd_n, w_wr_n;
  logic [OW-1:0] w_outst_n, w_discard_n;
  logic          w_hs, w_rsp_live, w_rsp_drop, w_push, w_pop;
  pfq_entry_t    w_head;

  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_head        = r_mem[r_rd_ptr];

  // Issue only while a queue slot is reserved for every live request; held low in reset.
  assign imem_req_valid = rstn && !redirect
                       && ((32'(r_count) + 32'(r_outst)) < DEPTH)
                       && ((32'(r_outst) + 32'(r_discard)) < MAX_OUTSTANDING);
  assign imem_req_addr  = r_fetch_pc;

  assign w_hs       = imem_req_valid && imem_req_ready;
  assign w_rsp_live = imem_rsp_valid && (r_discard == '0);
  assign w_rsp_drop = imem_rsp_valid && (r_discard != '0);
  assign w_push     = w_rsp_live && !redirect;
  assign w_pop      = out_valid && !stall && !redirect;

  assign out_valid  = (r_count != '0);
  assign out_instr  = out_valid ? w_head.instr : '0;
  assign out_pc     = out_valid ? w_head.pc : '0;
  assign out_pcnext = out_valid ? (w_head.pc + 32'd4) : '0;

  // Next-state: redirect overrides push, pop and issue.
  always_comb begin
    w_fetch_pc_n = r_fetch_pc;
    w_rsp_pc_n   = r_rsp_pc;
    w_count_n    = r_count;
    w_rd_n       = r_rd_ptr;
    w_wr_n       = r_wr_ptr;
    w_outst_n    = r_outst;
    w_discard_n  = r_discard;
    if (redirect) begin
      w_fetch_pc_n = w_redirect_pc;
      w_rsp_pc_n   = w_redirect_pc;
      w_count_n    = '0;
      w_rd_n       = '0;
      w_wr_n       = '0;
      w_outst_n    = '0;
      w_discard_n  = r_discard + r_outst - OW'(imem_rsp_valid);
    end else begin
      if (w_hs) w_fetch_pc_n = r_fetch_pc + 32'd4;
      if (w_push) begin
        w_rsp_pc_n = r_rsp_pc + 32'd4;
        w_wr_n     = r_wr_ptr + PW'(1);
      end
      if (w_pop) w_rd_n = r_rd_ptr + PW'(1);
      w_count_n   = r_count + CW'(w_push) - CW'(w_pop);
      w_outst_n   = r_outst + OW'(w_hs) - OW'(w_rsp_live);
      w_discard_n = r_discard - OW'(w_rsp_drop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_n;
      r_rsp_pc   <= w_rsp_pc_n;
      r_count    <= w_count_n;
      r_rd_ptr   <= w_rd_n;
      r_wr_ptr   <= w_wr_n;
      r_outst    <= w_outst_n;
      r_discard  <= w_discard_n;
    end
  end

  // Entry storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{pc: r_rsp_pc, instr: imem_rsp_data};
  end

`ifdef PFQ_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetch_cnt       <= '0;
      perf_drop_cnt        <= '0;
      perf_empty_stall_cnt <= '0;
    end else begin
      if (w_hs) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (imem_rsp_valid && !w_push) perf_drop_cnt <= perf_drop_cnt + 32'd1;
      if (!out_valid && !redirect) perf_empty_stall_cnt <= perf_empty_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed cycle table, hand sequences and random traffic,
// all checked against an epoch-tagged request/queue model.
module tb_instr_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect, stall, imem_req_ready, imem_rsp_valid;
  logic [31:0] redirect_pc, imem_rsp_data;
  logic        imem_req_valid, out_valid;
  logic [31:0] imem_req_addr, out_instr, out_pc, out_pcnext;
`ifdef PFQ_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt, perf_empty_stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk(clk), .rstn(rstn), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_pcnext(out_pcnext)
`ifdef PFQ_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt),
    .perf_empty_stall_cnt(perf_empty_stall_cnt)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;

  ent_t        mq[$];
  req_t        fl[$];
  int          epoch = 0, cyc = 0, lat_max = 1;
  logic [31:0] m_fetch = 32'h0;
  int          m_drops = 0, m_fetches = 0;
  int          checks = 0, errors = 0;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (fl[i]) if (fl[i].epoch == epoch) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, compare at +1, advance the model at posedge.
  // mode: 0 no beat, 1 forced beat, 2 beat when due. t_en adds fixed table expectations.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic st, input logic rdy,
                      input int mode, input logic t_en, input logic t_rv,
                      input logic [31:0] t_addr, input logic t_ov, input logic [31:0] t_pc);
    logic beat, e_rv;
    req_t f;
    @(negedge clk);
    redirect = rd; redirect_pc = rpc; stall = st; imem_req_ready = rdy;
    beat = 1'b0;
    if (fl.size() != 0) begin
      if (mode == 1) beat = 1'b1;
      else if (mode == 2 && fl[0].due <= cyc) beat = 1'b1;
    end
    imem_rsp_valid = beat;
    imem_rsp_data  = beat ? fdata(fl[0].addr) : $urandom;
    e_rv = !rd && ((mq.size() + live_cnt()) < DEPTH) && (fl.size() < MAXO);
    #1;
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    if (e_rv) chk("req_addr", imem_req_addr, m_fetch);
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", out_instr, mq[0].instr);
      chk("out_pcnext", out_pcnext, mq[0].pc + 32'd4);
    end
    if (t_en) begin
      chk("tbl_req_valid", 32'(imem_req_valid), 32'(t_rv));
      if (t_rv) chk("tbl_req_addr", imem_req_addr, t_addr);
      chk("tbl_out_valid", 32'(out_valid), 32'(t_ov));
      if (t_ov) chk("tbl_out_pc", out_pc, t_pc);
    end
    @(posedge clk);
    if (!rd && !st && mq.size() != 0) void'(mq.pop_front());
    if (beat) begin
      f = fl.pop_front();
      if (!rd && f.epoch == epoch) mq.push_back('{pc: f.addr, instr: fdata(f.addr)});
      else m_drops++;
    end
    if (rd) begin
      mq.delete();
      epoch++;
      m_fetch = rpc & 32'hFFFF_FFFC;
    end else if (e_rv && rdy) begin
      fl.push_back('{addr: m_fetch, epoch: epoch, due: cyc + 1 + int'($urandom_range(0, lat_max - 1))});
      m_fetch += 32'd4;
      m_fetches++;
    end
    cyc++;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pcnext", out_pcnext, 32'd0);
  endtask

  typedef struct {
    logic rd; logic [31:0] rpc; logic st; logic rdy; int rsp;
    logic rv; logic [31:0] addr; logic ov; logic [31:0] pc;
  } vec_t;
  vec_t tbl[20];

  initial begin
    tbl[0]  = '{0, 32'h0,   0, 1, 0, 1, 32'h000, 0, 32'h0};
    tbl[1]  = '{0, 32'h0,   0, 1, 1, 1, 32'h004, 0, 32'h0};
    tbl[2]  = '{0, 32'h0,   0, 1, 1, 1, 32'h008, 1, 32'h000};
    tbl[3]  = '{0, 32'h0,   0, 1, 1, 1, 32'h00C, 1, 32'h004};
    tbl[4]  = '{0, 32'h0,   0, 1, 1, 1, 32'h010, 1, 32'h008};
    tbl[5]  = '{0, 32'h0,   0, 1, 1, 1, 32'h014, 1, 32'h00C};
    tbl[6]  = '{1, 32'h103, 0, 1, 0, 0, 32'h0,   1, 32'h010};
    tbl[7]  = '{0, 32'h0,   0, 1, 1, 1, 32'h100, 0, 32'h0};
    tbl[8]  = '{0, 32'h0,   0, 1, 0, 1, 32'h104, 0, 32'h0};
    tbl[9]  = '{0, 32'h0,   0, 1, 1, 0, 32'h0,   0, 32'h0};
    tbl[10] = '{0, 32'h0,   1, 1, 0, 1, 32'h108, 1, 32'h100};
    tbl[11] = '{0, 32'h0,   1, 1, 1, 0, 32'h0,   1, 32'h100};
    tbl[12] = '{0, 32'h0,   0, 1, 0, 1, 32'h10C, 1, 32'h100};
    tbl[13] = '{1, 32'h200, 0, 1, 1, 0, 32'h0,   1, 32'h104};
    tbl[14] = '{0, 32'h0,   0, 1, 1, 1, 32'h200, 0, 32'h0};
    tbl[15] = '{0, 32'h0,   0, 1, 1, 1, 32'h204, 0, 32'h0};
    tbl[16] = '{0, 32'h0,   0, 0, 0, 1, 32'h208, 1, 32'h200};
    tbl[17] = '{0, 32'h0,   0, 0, 0, 1, 32'h208, 0, 32'h0};
    tbl[18] = '{0, 32'h0,   0, 1, 1, 1, 32'h208, 0, 32'h0};
    tbl[19] = '{0, 32'h0,   0, 1, 0, 1, 32'h20C, 1, 32'h204};

    rstn = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs();
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[i])
      step(tbl[i].rd, tbl[i].rpc, tbl[i].st, tbl[i].rdy, tbl[i].rsp,
           1'b1, tbl[i].rv, tbl[i].addr, tbl[i].ov, tbl[i].pc);

    // Fill under stall with 1-cycle responses, then drain one per cycle.
    lat_max = 1;
    repeat (12) step(0, 0, 1, 1, 2, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("full_req_blocked", 32'(imem_req_valid), 32'd0);
    chk("full_count", 32'(mq.size()), 32'(DEPTH));
    repeat (10) step(0, 0, 0, 1, 2, 0, 0, 0, 0, 0);

    // Ready held low: address must stay put until the handshake.
    step(1, 32'h0000_0010, 0, 1, 2, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 2, 1, 1, 32'h10, 0, 0);
    repeat (6) step(0, 0, 0, 1, 2, 0, 0, 0, 0, 0);

    // Random traffic with variable latency.
    lat_max = 4;
    for (int n = 0; n < 2500; n++)
      step(($urandom_range(0, 29) == 0), $urandom, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0), 2, 0, 0, 0, 0, 0);

    // Reset asserted mid-transfer clears state immediately.
    #2 rstn = 1'b0;
    redirect = 1'b0; imem_rsp_valid = 1'b0;
    #1 chk_reset_outputs();
    mq.delete(); fl.delete(); m_fetch = 32'h0; m_drops = 0; m_fetches = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0), 2, 0, 0, 0, 0, 0);

`ifdef PFQ_PERF_EN
    @(negedge clk); #1;
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'(m_fetches));
    chk("perf_drop_cnt", perf_drop_cnt, 32'(m_drops));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
